addr_nibble_serial_seq: RTL and testbench
=========================================

Name: addr_nibble_serial_seq

Overview:
- Sequential front-end that feeds the team's combinational 4-bit unsigned adder slice (A[3:0], B[3:0] -> O[4:0]), one nibble per cycle, and consumes its 5-bit result.
- Builds WIDTH-bit unsigned sums from the slice, chaining the carry internally because the slice has no carry-in.
- Checks every completed sum with a mod-3 residue code and retries the whole operation on mismatch, so a faulty slice is detected at system level.
- Sits between a valid/ready operand source and a valid/ready result sink.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- MAX_RETRY, 2, number of re-executions allowed after a residue mismatch before the result is flagged.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- slc_a  output  4  nibble of A driven to the adder slice.
- slc_b  output  4  nibble of B driven to the adder slice.
- slc_o  input  5  slice result {carry, sum[3:0]}, combinational from slc_a/slc_b.
- out_valid  output  1  result is valid.
- out_ready  input  1  sink accepts the result.
- out_sum  output  WIDTH+1  unsigned sum including the final carry.
- out_err  output  1  residue check still failed after MAX_RETRY retries.
- out_retries  output  $clog2(MAX_RETRY+1)  retries used for this result.

Behaviour:
- Reset: async assert. in_ready=0 while rst_n=0. After release: in_ready=1, out_valid=0, out_sum=0, out_err=0, out_retries=0, slc_a=slc_b=0, FSM=IDLE.
- Reset mid-operation aborts the operation and drops the result; no partial output is produced.
- FSM states and transitions:
  - IDLE: in_ready=1. An operand pair is accepted when in_valid&in_ready. The block latches A and B, sets nib=0, carry=0, the residue accumulators to 0 and retry=0, then goes to RUN.
  - RUN: one cycle per nibble, WIDTH/4 cycles total. slc_a=A[4*nib+:4] and slc_b=B[4*nib+:4] come straight from registers (no combinational path from inputs).
    - Per-cycle update:
      - s = slc_o[3:0] + carry, kept to 4 bits.
      - carry_next = slc_o[4] | (carry & (slc_o[3:0]==4'hF)).
      - Write s into sum[4*nib+:4].
      - Accumulate ra += a_nib mod 3, rb += b_nib mod 3, rs += s mod 3, all mod 3.
    - After the last nibble: sum[WIDTH] = carry_next, rs += carry_next, then go to CHECK.
  - CHECK: one cycle. The check passes when (ra+rb) mod 3 == rs. Both 16 and 2^WIDTH are ≡1 mod 3, which is why plain nibble sums are valid residues.
    - Pass: go to DONE with err=0.
    - Fail with retry<MAX_RETRY: retry+1, clear nib, carry and rs (ra and rb are kept), return to RUN.
    - Fail with retry==MAX_RETRY: go to DONE with err=1.
  - DONE: out_valid=1 and out_sum/out_err/out_retries are held stable until out_ready.
    - On out_valid&out_ready: go to IDLE and deassert out_valid. in_ready rises the following cycle; there is no same-cycle accept.
- Latency, fault-free: accept at cycle 0, out_valid high at cycle WIDTH/4+2. Each retry adds WIDTH/4+1 cycles.
- Throughput: one operation in flight; in_ready=0 in RUN, CHECK and DONE.
- Holding slc_a/slc_b at 0 outside RUN keeps slice switching power down.
- Simultaneous events: out_ready asserted before out_valid has no effect. in_valid outside IDLE is ignored, and the source must hold its data.
- Wrap-around: the final carry is never lost, because out_sum is WIDTH+1 bits.
- Limitation: a slice fault that corrupts s by a multiple of 3 is undetected by design.

Decomposition:
- Package addr_seq_pkg contains:
  - state enum {IDLE, RUN, CHECK, DONE};
  - function nib_mod3(4-bit) -> 2-bit;
  - function add_mod3(2-bit, 2-bit) -> 2-bit;
  - localparam helper NIBBLES = WIDTH/4.
- One sub-module, res3_acc: a 2-bit residue accumulator with clear and enable. It is instantiated three times, for ra, rb and rs.

Test Plan:
- WIDTH=16, golden slice model, A=0x1234, B=0x4321 -> out_sum=0x05555, out_err=0, out_retries=0, out_valid 6 cycles after accept.
- A=0xFFFF, B=0x0001 -> out_sum=0x10000, covering the carry ripple through all nibbles via the injected-carry path.
- A=0xFFFF, B=0xFFFF -> out_sum=0x1FFFE, err=0.
- Transient fault: the slice model flips slc_o[0] on the first pass only, with A=0x0003, B=0x0004 -> out_sum=0x00007, out_retries=1, err=0, out_valid at cycle 11.
- Stuck-at fault: slc_o[1] is stuck at 1 permanently, A=0, B=0 -> out_err=1, out_retries=2, out_valid at cycle 16. Also check back-pressure: out_ready held low for 5 cycles keeps outputs stable and in_ready=0.
- rst_n pulsed low during RUN (nibble 2) -> outputs return to reset values immediately, no out_valid. A new op 0x0001+0x0001 then returns 0x00002.

Source files
------------

// File: rtl/addr_nibble_serial_seq_pkg.sv
// addr_seq_pkg: shared FSM states and mod-3 residue helpers for the nibble-serial adder front-end
package addr_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  function automatic int nibbles(input int width);
    return width / 4;
  endfunction
  function automatic logic [1:0] nib_mod3(input logic [3:0] n);
    return 2'(n % 4'd3);
  endfunction
  function automatic logic [1:0] add_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] t;
    t = {1'b0, x} + {1'b0, y};
    return t >= 3'd3 ? 2'(t - 3'd3) : t[1:0];
  endfunction
endpackage

// File: rtl/addr_nibble_serial_seq_if.sv
// addr_nibble_serial_seq_if: operand, slice and result handshake bundle
interface addr_nibble_serial_seq_if #(
  parameter int WIDTH = 16,
  parameter int MAX_RETRY = 2
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0] slc_a;
  logic [3:0] slc_b;
  logic [4:0] slc_o;
  logic out_valid;
  logic out_ready;
  logic [WIDTH:0] out_sum;
  logic out_err;
  logic [RW-1:0] out_retries;
  modport master (
    output in_valid, in_a, in_b, slc_o, out_ready,
    input in_ready, slc_a, slc_b, out_valid, out_sum, out_err, out_retries
  );
  modport slave (
    input in_valid, in_a, in_b, slc_o, out_ready,
    output in_ready, slc_a, slc_b, out_valid, out_sum, out_err, out_retries
  );
endinterface

// File: rtl/addr_nibble_serial_seq_res3_acc.sv
// res3_acc: 2-bit mod-3 residue accumulator with clear and enable
module res3_acc
  import addr_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] d,
  output logic [1:0] q
);
  // clear wins over accumulate so a new operation never inherits old residue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= clr ? 2'd0 : en ? add_mod3(q, d) : q;
endmodule

// File: rtl/addr_nibble_serial_seq.sv
// addr_nibble_serial_seq: nibble-serial WIDTH-bit adder driving a 4-bit slice, with mod-3 checked retry
module addr_nibble_serial_seq
  import addr_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_RETRY = 2
) (
  input logic clk,
  input logic rst_n,
  addr_nibble_serial_seq_if.slave bus
);
  localparam int NIBBLES = nibbles(WIDTH);
  localparam int NW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0] sum_r;
  logic [NW-1:0] nib;
  logic [RW-1:0] retry;
  logic carry, err;
  logic [3:0] s;
  logic carry_next, last, acc, pass, rerun;
  logic [1:0] ra, rb, rs, s_res;
  // slice operands come only from latched registers and idle at zero outside RUN
  assign bus.slc_a = state == RUN ? a_r[4*nib +: 4] : 4'd0;
  assign bus.slc_b = state == RUN ? b_r[4*nib +: 4] : 4'd0;
  assign bus.in_ready = rst_n && state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_sum = sum_r;
  assign bus.out_err = err;
  assign bus.out_retries = retry;
  // the slice has no carry-in, so the previous carry is folded in here
  always_comb begin
    s = bus.slc_o[3:0] + {3'd0, carry};
    carry_next = bus.slc_o[4] | (carry & (bus.slc_o[3:0] == 4'hF));
    last = nib == NW'(NIBBLES - 1);
    acc = state == IDLE && bus.in_valid;
    pass = add_mod3(ra, rb) == rs;
    rerun = state == CHECK && !pass && retry != RW'(MAX_RETRY);
    s_res = last ? add_mod3(nib_mod3(s), {1'b0, carry_next}) : nib_mod3(s);
  end
  // operand residues are taken on the first pass only and reused by retries
  res3_acc u_ra (.clk(clk), .rst_n(rst_n), .clr(acc), .en(state == RUN && retry == '0), .d(nib_mod3(bus.slc_a)), .q(ra));
  res3_acc u_rb (.clk(clk), .rst_n(rst_n), .clr(acc), .en(state == RUN && retry == '0), .d(nib_mod3(bus.slc_b)), .q(rb));
  res3_acc u_rs (.clk(clk), .rst_n(rst_n), .clr(acc | rerun), .en(state == RUN), .d(s_res), .q(rs));
  // sequencing: accept, one nibble per cycle, residue check with retry, hold result until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      nib <= '0;
      carry <= 1'b0;
      retry <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (acc) begin
            a_r <= bus.in_a;
            b_r <= bus.in_b;
            nib <= '0;
            carry <= 1'b0;
            retry <= '0;
            err <= 1'b0;
            state <= RUN;
          end
        RUN: begin
          sum_r[4*nib +: 4] <= s;
          carry <= carry_next;
          nib <= nib + 1'b1;
          if (last) begin
            sum_r[WIDTH] <= carry_next;
            state <= CHECK;
          end
        end
        CHECK:
          if (pass) state <= DONE;
          else if (!rerun) begin
            err <= 1'b1;
            state <= DONE;
          end else begin
            retry <= retry + 1'b1;
            nib <= '0;
            carry <= 1'b0;
            state <= RUN;
          end
        default:
          if (bus.out_ready) state <= IDLE;
      endcase
endmodule

// File: tb/tb_addr_nibble_serial_seq.sv
// tb_addr_nibble_serial_seq: scoreboard bench with a golden/faulty 4-bit slice model
module tb_addr_nibble_serial_seq;
  typedef struct {
    logic [16:0] sum;
    logic err;
    logic [1:0] ret;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int fault = 0;
  int cyc = 0;
  int t0 = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [4:0] g;
  addr_nibble_serial_seq_if #(.WIDTH(16), .MAX_RETRY(2)) bus ();
  addr_nibble_serial_seq #(.WIDTH(16), .MAX_RETRY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    g = {1'b0, bus.slc_a} + {1'b0, bus.slc_b};
    bus.slc_o = fault == 1 && bus.out_retries == 2'd0 ? g ^ 5'd1 : fault == 2 ? g | 5'd2 : g;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int f,
                      input logic [16:0] sum, input logic err, input logic [1:0] ret);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.in_ready), 1);
    fault = f;
    bus.in_valid = 1;
    bus.in_a = a;
    bus.in_b = b;
    t0 = cyc;
    e.sum = sum;
    e.err = err;
    e.ret = ret;
    e.lat = 6 + 5 * int'(ret);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic receive(input int hold);
    exp_t e;
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk("out_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc - t0), 32'(e.lat));
    chk("out_sum", 32'(bus.out_sum), 32'(e.sum));
    chk("out_err", 32'(bus.out_err), 32'(e.err));
    chk("out_retries", 32'(bus.out_retries), 32'(e.ret));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_sum", 32'(bus.out_sum), 32'(e.sum));
      chk("hold_err", 32'(bus.out_err), 32'(e.err));
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("ready_back", 32'(bus.in_ready), 1);
  endtask
  initial begin
    int seen;
    bus.in_valid = 0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.out_sum), 0);
    chk("rst_err", 32'(bus.out_err), 0);
    chk("rst_retries", 32'(bus.out_retries), 0);
    chk("rst_slc", {24'd0, bus.slc_a, bus.slc_b}, 0);
    send(16'h1234, 16'h4321, 0, 17'h05555, 0, 0);
    receive(0);
    send(16'hFFFF, 16'h0001, 0, 17'h10000, 0, 0);
    receive(0);
    send(16'hFFFF, 16'hFFFF, 0, 17'h1FFFE, 0, 0);
    receive(0);
    send(16'h0003, 16'h0004, 1, 17'h00007, 0, 1);
    receive(0);
    bus.out_ready = 0;
    send(16'h0000, 16'h0000, 2, 17'h02222, 1, 2);
    receive(5);
    send(16'h1111, 16'h2222, 0, 17'h03333, 0, 0);
    repeat (2) @(negedge clk);
    chk("run_nib2_slc", {24'd0, bus.slc_a, bus.slc_b}, 32'h12);
    rst_n = 0;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_ready", 32'(bus.in_ready), 0);
    chk("abort_sum", 32'(bus.out_sum), 0);
    chk("abort_slc", {24'd0, bus.slc_a, bus.slc_b}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("abort_no_out", 32'(seen), 0);
    send(16'h0001, 16'h0001, 0, 17'h00002, 0, 0);
    receive(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
